// File: rtl/branch_cond_sequencer.sv
// branch_cond_sequencer
// Runs one conditional-branch evaluation per accepted start. It requests the shared
// BUS, has the register file drive Ra onto it for one cycle, tests Ra against the
// captured IR condition field and reports the result on con_q and pc_load. If the
// arbiter never grants the bus, the request is abandoned and the sticky timeout is set.
module branch_cond_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int COND_LSB       = 19,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  bus_gnt,
    input  logic [DATA_WIDTH-1:0] BUS,
    output logic                  bus_req,
    output logic                  reg_out,
    output logic                  con_q,
    output logic                  pc_load,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Condition codes held in IR[COND_LSB+1:COND_LSB].
    typedef enum logic [1:0] {
        COND_ZR = 2'b00,  // brzr: Ra == 0
        COND_NZ = 2'b01,  // brnz: Ra != 0
        COND_PL = 2'b10,  // brpl: Ra >= 0
        COND_MI = 2'b11   // brmi: Ra <  0
    } cond_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_EVAL,
        S_COMMIT,
        S_TOUT
    } state_t;

    state_t                state;
    state_t                state_next;
    cond_t                 cond_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  accept;
    logic                  gnt_expired;
    logic                  flag;
    logic                  unused_ir;

    // Only the condition field of IR matters; the rest is consumed here on purpose.
    assign unused_ir = ^IR;

    assign accept      = (state == S_IDLE) && start;
    assign gnt_expired = (state == S_REQ) && !bus_gnt && (cnt_q == CNT_LAST);

    // State register; Reset aborts any operation on the same edge.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: a default assignment on entry means no path leaves state_next
        // unassigned, so no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_REQ;
            S_REQ: begin
                if (bus_gnt)          state_next = S_READ;
                else if (gnt_expired) state_next = S_TOUT;
            end
            S_READ:   state_next = S_EVAL;
            S_EVAL:   state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            S_TOUT:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        bus_req = (state == S_REQ) || (state == S_READ);
        reg_out = (state == S_READ);
        busy    = (state != S_IDLE);
        done    = (state == S_COMMIT) || (state == S_TOUT);
        pc_load = (state == S_COMMIT) && con_q;
    end

    // Branch condition applied to the captured Ra value.
    always_comb begin
        flag = 1'b0;
        unique case (cond_q)
            COND_ZR: flag = (data_q == '0);
            COND_NZ: flag = (data_q != '0);
            COND_PL: flag = !data_q[DATA_WIDTH-1];
            COND_MI: flag = data_q[DATA_WIDTH-1];
            default: flag = 1'b0;
        endcase
    end

    // Control registers: condition capture, grant-wait counter, branch flag, timeout.
    // timeout and con_q update on the edge into TOUT so they are visible alongside done.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cond_q  <= COND_ZR;
            cnt_q   <= '0;
            con_q   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (accept) begin
                cond_q  <= cond_t'(IR[COND_LSB +: 2]);
                cnt_q   <= '0;
                timeout <= 1'b0;
            end else if ((state == S_REQ) && !bus_gnt) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state == S_EVAL) begin
                con_q <= flag;
            end

            if (gnt_expired) begin
                timeout <= 1'b1;
                con_q   <= 1'b0;
            end
        end
    end

    // Ra capture while the register file drives the BUS.
    always_ff @(posedge Clk) begin
        // NOTE: the data register has no reset; it is always written in READ before
        // EVAL consumes it, so its power-up value is never observed.
        if (state == S_READ) begin
            data_q <= BUS;
        end
    end

endmodule
